atm: RTL and testbench



---
 rtl/atm_pkg.sv | 20 ++
 rtl/atm.sv | 144 ++++++++++++++
 tb/tb_atm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM state encoding and menu op-codes.
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LANG    = 3'd1,
    PIN     = 3'd2,
    MENU    = 3'd3,
    BAL     = 3'd4,
    DEP     = 3'd5,
    WDR     = 3'd6,
    ANOTHER = 3'd7
  } state_e;

  localparam logic [1:0] OP_BAL  = 2'b00;
  localparam logic [1:0] OP_DEP  = 2'b01;
  localparam logic [1:0] OP_WDR  = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

endpackage

// File: rtl/atm.sv
// Single-account ATM session FSM with persistent balance and registered transaction outputs.
// Latency: one clock per state, outputs update on the clock that leaves BAL/DEP/WDR; no backpressure.
module atm
  import atm_pkg::*;
#(
  parameter int unsigned BAL_W        = 8,
  parameter logic [3:0]  PIN_CODE     = 4'hF,
  parameter int unsigned INIT_BALANCE = 10,
  parameter int unsigned MAX_TRIES    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_card,
  input  logic             in_Lang,
  input  logic [3:0]       in_PIN,
  input  logic [1:0]       in_operation,
  input  logic [3:0]       depositAmount,
  input  logic [3:0]       withdrawAmount,
  input  logic             in_AnotherOp,
  output logic [BAL_W-1:0] Balance_out,
  output logic             O_NotEnough
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [BAL_W-1:0] INIT_BAL = BAL_W'(INIT_BALANCE);
  localparam logic [BAL_W-1:0] BAL_MAX  = '1;

  state_e             state_q, state_d;
  logic [BAL_W-1:0]   balance_q, balance_d;
  logic [BAL_W-1:0]   bal_out_q, bal_out_d;
  logic               ne_q, ne_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic               lang_q, lang_d;

  logic [BAL_W:0]     dep_sum;
  logic [BAL_W-1:0]   dep_bal;
  logic [BAL_W-1:0]   wd_ext;
  logic               wd_ok;
  logic               pin_ok;
  logic               last_try;

  assign dep_sum  = {1'b0, balance_q} + (BAL_W+1)'(depositAmount);
  assign dep_bal  = dep_sum[BAL_W] ? BAL_MAX : dep_sum[BAL_W-1:0];
  assign wd_ext   = BAL_W'(withdrawAmount);
  assign wd_ok    = (wd_ext <= balance_q);
  assign pin_ok   = (in_PIN == PIN_CODE);
  assign last_try = ((32'(tries_q) + 32'd1) >= MAX_TRIES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_card) state_d = LANG;
      LANG:    state_d = PIN;
      PIN: begin
        if (pin_ok)        state_d = MENU;
        else if (last_try) state_d = IDLE;
      end
      MENU: begin
        case (in_operation)
          OP_BAL:  state_d = BAL;
          OP_DEP:  state_d = DEP;
          OP_WDR:  state_d = WDR;
          default: state_d = IDLE;
        endcase
      end
      BAL, DEP, WDR: state_d = ANOTHER;
      ANOTHER: state_d = in_AnotherOp ? MENU : IDLE;
      default: state_d = IDLE;
    endcase
    // Pulling the card wins over every other transition.
    if (!in_card && state_q != IDLE) state_d = IDLE;
  end

  // Datapath updates are suppressed when the card is pulled in the same cycle.
  always_comb begin
    balance_d = balance_q;
    bal_out_d = bal_out_q;
    ne_d      = ne_q;
    tries_d   = tries_q;
    lang_d    = lang_q;
    case (state_q)
      IDLE: tries_d = '0;
      LANG: if (in_card) lang_d = in_Lang;
      PIN: begin
        if (!in_card || pin_ok || last_try) tries_d = '0;
        else                                tries_d = tries_q + TRY_W'(1);
      end
      BAL: begin
        if (in_card) begin
          bal_out_d = balance_q;
          ne_d      = 1'b0;
        end
      end
      DEP: begin
        if (in_card) begin
          balance_d = dep_bal;
          bal_out_d = dep_bal;
          ne_d      = 1'b0;
        end
      end
      WDR: begin
        if (in_card) begin
          if (wd_ok) begin
            balance_d = balance_q - wd_ext;
            bal_out_d = balance_q - wd_ext;
            ne_d      = 1'b0;
          end else begin
            bal_out_d = balance_q;
            ne_d      = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      balance_q <= INIT_BAL;
      bal_out_q <= '0;
      ne_q      <= 1'b0;
      tries_q   <= '0;
      lang_q    <= 1'b0;
    end else begin
      balance_q <= balance_d;
      bal_out_q <= bal_out_d;
      ne_q      <= ne_d;
      tries_q   <= tries_d;
      lang_q    <= lang_d;
    end
  end

  assign Balance_out = bal_out_q;
  assign O_NotEnough = ne_q;

endmodule

// File: tb/tb_atm.sv
// Directed vector bench for the ATM controller: one record per clock, plus reset and saturation sequences.
module tb_atm;
  import atm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_card, in_Lang, in_AnotherOp;
  logic [3:0] in_PIN, depositAmount, withdrawAmount;
  logic [1:0] in_operation;
  logic [7:0] Balance_out;
  logic       O_NotEnough;

  int n_cmp = 0;
  int n_err = 0;

  atm dut (
    .clk            (clk),
    .rst            (rst),
    .in_card        (in_card),
    .in_Lang        (in_Lang),
    .in_PIN         (in_PIN),
    .in_operation   (in_operation),
    .depositAmount  (depositAmount),
    .withdrawAmount (withdrawAmount),
    .in_AnotherOp   (in_AnotherOp),
    .Balance_out    (Balance_out),
    .O_NotEnough    (O_NotEnough)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       card;
    logic       lang;
    logic [3:0] pin;
    logic [1:0] op;
    logic [3:0] dep;
    logic [3:0] wd;
    logic       another;
    state_e     st;
    logic [7:0] bo;
    logic       ne;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic l, input logic [3:0] p,
                              input logic [1:0] o, input logic [3:0] d, input logic [3:0] w,
                              input logic a, input state_e s, input logic [7:0] b, input logic n);
    vec_t v;
    v.card = c; v.lang = l; v.pin = p; v.op = o; v.dep = d; v.wd = w;
    v.another = a; v.st = s; v.bo = b; v.ne = n;
    return v;
  endfunction

  task automatic add(input logic c, input logic l, input logic [3:0] p, input logic [1:0] o,
                     input logic [3:0] d, input logic [3:0] w, input logic a,
                     input state_e s, input logic [7:0] b, input logic n);
    vecs.push_back(mk(c, l, p, o, d, w, a, s, b, n));
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    in_card        = v.card;
    in_Lang        = v.lang;
    in_PIN         = v.pin;
    in_operation   = v.op;
    depositAmount  = v.dep;
    withdrawAmount = v.wd;
    in_AnotherOp   = v.another;
    @(posedge clk);
    #1;
    chk("state", idx, 32'(dut.state_q), 32'(v.st));
    chk("bal_out", idx, 32'(Balance_out), 32'(v.bo));
    chk("not_enough", idx, 32'(O_NotEnough), 32'(v.ne));
  endtask

  initial begin
    int exp_bal;

    rst = 1'b0;
    in_card = 0; in_Lang = 0; in_PIN = 0; in_operation = 0;
    depositAmount = 0; withdrawAmount = 0; in_AnotherOp = 0;

    //  card lang pin   op     dep wd another  state    bal ne
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, LANG,    0,  0);
    add(1, 1, 4'h0, 2'b00, 0, 0, 0, PIN,     0,  0);
    add(1, 0, 4'hF, 2'b00, 0, 0, 0, MENU,    0,  0);
    add(1, 0, 4'h0, 2'b10, 0, 0, 0, WDR,     0,  0);
    add(1, 0, 4'h0, 2'b00, 0, 4, 0, ANOTHER, 6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 1, MENU,    6,  0);
    add(1, 0, 4'h0, 2'b01, 0, 0, 0, DEP,     6,  0);
    add(1, 0, 4'h0, 2'b00, 4, 0, 0, ANOTHER, 10, 0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 1, MENU,    10, 0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, BAL,     10, 0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, ANOTHER, 10, 0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 1, MENU,    10, 0);
    add(1, 0, 4'h0, 2'b10, 0, 0, 0, WDR,     10, 0);
    add(1, 0, 4'h0, 2'b00, 0, 15, 0, ANOTHER, 10, 1);
    add(1, 0, 4'h0, 2'b00, 0, 0, 1, MENU,    10, 1);
    add(1, 0, 4'h0, 2'b10, 0, 0, 0, WDR,     10, 1);
    add(1, 0, 4'h0, 2'b00, 0, 4, 0, ANOTHER, 6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, IDLE,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, LANG,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, PIN,     6,  0);
    add(1, 0, 4'h5, 2'b00, 0, 0, 0, PIN,     6,  0);
    add(1, 0, 4'h5, 2'b00, 0, 0, 0, PIN,     6,  0);
    add(1, 0, 4'hF, 2'b00, 0, 0, 0, MENU,    6,  0);
    add(1, 0, 4'h0, 2'b11, 0, 0, 0, IDLE,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, LANG,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, PIN,     6,  0);
    add(1, 0, 4'h5, 2'b00, 0, 0, 0, PIN,     6,  0);
    add(1, 0, 4'h5, 2'b00, 0, 0, 0, PIN,     6,  0);
    add(1, 0, 4'h5, 2'b00, 0, 0, 0, IDLE,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, LANG,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, PIN,     6,  0);
    add(1, 0, 4'h5, 2'b00, 0, 0, 0, PIN,     6,  0);
    add(1, 0, 4'hF, 2'b00, 0, 0, 0, MENU,    6,  0);
    add(0, 0, 4'h0, 2'b01, 0, 0, 0, IDLE,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, LANG,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, PIN,     6,  0);
    add(1, 0, 4'hF, 2'b00, 0, 0, 0, MENU,    6,  0);
    add(1, 0, 4'h0, 2'b01, 0, 0, 0, DEP,     6,  0);
    add(0, 0, 4'h0, 2'b00, 9, 0, 0, IDLE,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, LANG,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, PIN,     6,  0);
    add(1, 0, 4'hF, 2'b00, 0, 0, 0, MENU,    6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, BAL,     6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, ANOTHER, 6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 1, MENU,    6,  0);
    add(1, 0, 4'h0, 2'b10, 0, 0, 0, WDR,     6,  0);
    add(1, 0, 4'h0, 2'b00, 0, 6, 0, ANOTHER, 0,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 1, MENU,    0,  0);
    add(1, 0, 4'h0, 2'b10, 0, 0, 0, WDR,     0,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, ANOTHER, 0,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 1, MENU,    0,  0);
    add(1, 0, 4'h0, 2'b01, 0, 0, 0, DEP,     0,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, ANOTHER, 0,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 1, MENU,    0,  0);
    add(1, 0, 4'h0, 2'b01, 0, 0, 0, DEP,     0,  0);
    add(1, 0, 4'h0, 2'b00, 9, 0, 0, ANOTHER, 9,  0);
    add(1, 0, 4'h0, 2'b00, 0, 0, 0, IDLE,    9,  0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 0, 32'(dut.state_q), 32'(IDLE));
    chk("reset_bal_out", 0, 32'(Balance_out), 32'd0);
    chk("reset_not_enough", 0, 32'(O_NotEnough), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // Async reset while sitting in DEP: takes effect without a clock edge.
    apply(mk(1, 0, 4'h0, 2'b00, 0, 0, 0, LANG, 9, 0), 100);
    apply(mk(1, 0, 4'h0, 2'b00, 0, 0, 0, PIN,  9, 0), 101);
    apply(mk(1, 0, 4'hF, 2'b00, 0, 0, 0, MENU, 9, 0), 102);
    apply(mk(1, 0, 4'h0, 2'b01, 0, 0, 0, DEP,  9, 0), 103);
    depositAmount = 4'd7;
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 104, 32'(dut.state_q), 32'(IDLE));
    chk("arst_bal_out", 104, 32'(Balance_out), 32'd0);
    chk("arst_not_enough", 104, 32'(O_NotEnough), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    apply(mk(1, 0, 4'h0, 2'b00, 0, 0, 0, LANG,    0,  0), 110);
    apply(mk(1, 0, 4'h0, 2'b00, 0, 0, 0, PIN,     0,  0), 111);
    apply(mk(1, 0, 4'hF, 2'b00, 0, 0, 0, MENU,    0,  0), 112);
    apply(mk(1, 0, 4'h0, 2'b00, 0, 0, 0, BAL,     0,  0), 113);
    apply(mk(1, 0, 4'h0, 2'b00, 0, 0, 0, ANOTHER, 10, 0), 114);

    exp_bal = 10;
    for (int k = 0; k < 18; k++) begin
      apply(mk(1, 0, 4'h0, 2'b00, 0, 0, 1, MENU, 8'(exp_bal), 0), 200 + 3*k);
      apply(mk(1, 0, 4'h0, 2'b01, 0, 0, 0, DEP,  8'(exp_bal), 0), 201 + 3*k);
      exp_bal = (exp_bal + 15 > 255) ? 255 : exp_bal + 15;
      apply(mk(1, 0, 4'h0, 2'b00, 15, 0, 0, ANOTHER, 8'(exp_bal), 0), 202 + 3*k);
    end
    chk("saturated", 300, 32'(Balance_out), 32'd255);
    apply(mk(1, 0, 4'h0, 2'b00, 0, 0, 0, IDLE, 255, 0), 301);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
